// File: rtl/serial_full_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first, one bit per clock.
// Result and carry-out are registered on completion and held until the next completion or reset.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one operand bit summed per clock
// DONE  | result valid, done strobe high; start here begins a new addition
module serial_full_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;

  logic             bit_s;
  logic             bit_c;
  logic [WIDTH-1:0] acc_shift;

  assign bit_s     = sa_q[0] ^ sb_q[0] ^ c_q;
  assign bit_c     = (sa_q[0] & sb_q[0]) | (sa_q[0] & c_q) | (sb_q[0] & c_q);
  assign acc_shift = {bit_s, acc_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          c_d     = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        c_d   = bit_c;
        acc_d = acc_shift;
        cnt_d = cnt_q + CW'(1);
        // last bit: the accumulator is complete including the bit being shifted in now
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = acc_shift;
          cout_d  = bit_c;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_full_adder.sv
// Directed bench for serial_full_adder: 8-bit vector table, multi-cycle corner cases,
// and an exhaustive sweep on a 3-bit instance.
module tb_serial_full_adder;

  logic       clk;
  logic       rst_n;

  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;

  logic       start3, cin3, busy3, done3, cout3;
  logic [2:0] a3, b3, sum3;

  int total = 0;
  int bad   = 0;

  serial_full_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_full_adder #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .cin(cin3),
    .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Issue one 8-bit addition; returns cycles from acceptance to done and RUN-cycle count.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      output int lat, output int busy_cnt);
    @(negedge clk);
    a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 0;
    busy_cnt = 0;
    while (!done8 && lat < 50) begin
      if (busy8) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run3(input logic [2:0] a, input logic [2:0] b, input logic cin, output int lat);
    @(negedge clk);
    a3 = a; b3 = b; cin3 = cin; start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    lat = 0;
    while (!done3 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, busy_cnt, n, extra;
    logic [3:0] exp3;

    vecs[0] = '{8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1};
    vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs[7] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};

    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start3 = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy8), 32'(0));
    chk("reset_done", 32'(done8), 32'(0));
    chk("reset_sum",  32'(sum8),  32'(0));
    chk("reset_cout", 32'(cout8), 32'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].cin, lat, busy_cnt);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(8));
      chk($sformatf("vec%0d_busy_cycles", i), 32'(busy_cnt), 32'(8));
      chk($sformatf("vec%0d_sum", i), 32'(sum8), 32'(vecs[i].exp_sum));
      chk($sformatf("vec%0d_cout", i), 32'(cout8), 32'(vecs[i].exp_cout));
      @(negedge clk);
      chk($sformatf("vec%0d_done_one_cycle", i), 32'(done8), 32'(0));
      chk($sformatf("vec%0d_sum_held", i), 32'(sum8), 32'(vecs[i].exp_sum));
    end

    // start held high and operands scrambled during RUN
    @(negedge clk);
    a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    lat = 0;
    while (!done8 && lat < 50) begin
      if (lat < 6) begin
        a8 = ~a8; b8 = b8 + 8'h37; cin8 = ~cin8;
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start8 = 1'b0;
    chk("hold_latency", 32'(lat), 32'(8));
    chk("hold_sum", 32'(sum8), 32'(8'h33));
    chk("hold_cout", 32'(cout8), 32'(0));
    extra = 0;
    repeat (15) begin
      @(negedge clk);
      if (done8) extra++;
    end
    chk("hold_no_extra_done", 32'(extra), 32'(0));

    // reset during the 4th RUN cycle
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_busy_before", 32'(busy8), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy8), 32'(0));
    chk("abort_done", 32'(done8), 32'(0));
    chk("abort_sum",  32'(sum8),  32'(0));
    chk("abort_cout", 32'(cout8), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (done8 || busy8) extra++;
    end
    chk("abort_no_done", 32'(extra), 32'(0));

    // back-to-back: start in the DONE cycle
    run8(8'h3C, 8'h5A, 1'b0, lat, busy_cnt);
    chk("b2b_first_latency", 32'(lat), 32'(8));
    chk("b2b_first_sum", 32'(sum8), 32'(8'h96));
    a8 = 8'h01; b8 = 8'h02; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n = 1;
    while (!done8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_spacing", 32'(n), 32'(9));
    chk("b2b_second_sum", 32'(sum8), 32'(8'h04));
    chk("b2b_second_cout", 32'(cout8), 32'(0));

    // WIDTH=3 exhaustive
    for (int ia = 0; ia < 8; ia++) begin
      for (int ib = 0; ib < 8; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          run3(3'(ia), 3'(ib), 1'(ic), lat);
          exp3 = 4'(ia + ib + ic);
          chk($sformatf("w3_%0d_%0d_%0d", ia, ib, ic), 32'({cout3, sum3}), 32'(exp3));
          chk($sformatf("w3_lat_%0d_%0d_%0d", ia, ib, ic), 32'(lat), 32'(3));
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
